control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter: STEP_BITS, 3, width of the microstep counter; the largest step index it can hold SHALL be at least 4.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 opcode  input  4  upper nibble of the instruction register.
REQ-005 CY  input  1  carry flag from the ALU, combinational.
REQ-006 Z  input  1  zero flag from the ALU, combinational.
REQ-007 HLT, MI, RI, RO, IO, II, AI, AO, BI, BO, EO, SU, OI, CE, CO, J, FI  output  1 each  control lines: halt, MAR in, RAM in/out, IR out/in, A in/out, B in/out, ALU out, subtract, output-reg in, PC enable/out, jump, flags in.
REQ-008 step  output  STEP_BITS  current microstep, for debug.
REQ-009 flag_c, flag_z  output  1 each  latched carry and zero flags.

Function
REQ-010 Control outputs SHALL be a combinational function of opcode, step, flag_c and flag_z only.
REQ-011 Step 0 SHALL assert CO, MI; step 1 SHALL assert RO, II, CE, for every opcode.
REQ-012 Execute steps from step 2: NOP 0000: none. LDA 0001: IO,MI / RO,AI. ADD 0010: IO,MI / RO,BI / EO,AI,FI. SUB 0011: as ADD plus SU on the last step.
REQ-013 STA 0100: IO,MI / AO,RI. LDI 0101: IO,AI. JMP 0110: IO,J. JC 0111: IO,J only if flag_c=1. JZ 1000: IO,J only if flag_z=1. OUT 1110: AO,OI. HLT 1111: HLT.
REQ-014 Opcodes 1001-1101 SHALL decode as NOP.
REQ-015 Each opcode SHALL have a fixed last step: 1 for NOP and undefined opcodes; 2 for LDI, JMP, JC, JZ, OUT and HLT; 3 for LDA and STA; 4 for ADD and SUB. This length SHALL NOT depend on flags. An untaken JC or JZ SHALL spend step 2 with no control lines asserted.
REQ-016 On a rising edge, step SHALL clear to 0 if it equals the opcode's last step; otherwise it SHALL increment by 1.
REQ-017 While HLT is asserted, step SHALL hold its value. Only rst leaves the halted state.
REQ-018 Flags register: on a rising edge with FI=1, flag_c<=CY and flag_z<=Z; with FI=0 the flags SHALL hold.
REQ-019 At most one bus driver (RO, IO, AO, BO, EO, CO) SHALL be asserted in any step; at most one of MI, RI, II, AI, BI, OI, J SHALL be asserted except the documented pairs.
REQ-020 The opcode value at the end-of-step edge decides the step clear; the bench SHALL hold opcode stable within an instruction.

Reset
REQ-021 rst=1 SHALL force step=0, flag_c=0 and flag_z=0 immediately, without waiting for a clock edge.
REQ-022 During reset the outputs SHALL equal the step-0 word: CO=1, MI=1, all other controls 0.
REQ-023 Reset asserted mid-instruction, including while halted, SHALL abandon the instruction. Fetch SHALL resume at step 0 on the first edge after release.

Structure
REQ-024 A shared package SHALL hold the opcode constants, the control-word bit indices and the per-opcode last-step table.
REQ-025 The microcode decode SHALL be one combinational sub-module, control_rom (inputs opcode, step, flags; output control word). control_sequencer SHALL hold only the step counter and the flags register.

Verification
REQ-026 Reset, then opcode=0001 (LDA): steps 0,1,2,3 SHALL give {CO,MI}, {RO,II,CE}, {IO,MI}, {RO,AI}, then step 0 again on the fifth edge.
REQ-027 ADD with CY=1, Z=0 at step 4: EO, AI, FI SHALL be asserted, and after the edge flag_c=1, flag_z=0. A following SUB with CY=0, Z=1 SHALL give flag_c=0, flag_z=1.
REQ-028 JC with flag_c=0: step 2 SHALL assert no controls and step SHALL return to 0 after it. With flag_c=1: step 2 SHALL assert IO and J.
REQ-029 HLT (1111): at step 2 HLT=1, and step SHALL stay 2 for 10 clocks. Asserting rst SHALL give step=0 asynchronously with CO=MI=1.
REQ-030 Opcode 1010 (undefined): the instruction SHALL take 2 steps with no execute controls. rst pulsed at step 3 of STA SHALL give step=0 and flags 0 with no clock edge.
REQ-031 Every step of every opcode (all flag combinations) SHALL be checked against REQ-019 exclusivity.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// ============================================================================
// Module      : control_sequencer_pkg
// Description : Opcodes, control-word bit indices and last-step table shared
//               by the microcode ROM and the step sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package control_sequencer_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  localparam int unsigned c_ctrl_width = 17;

  localparam int unsigned c_bit_hlt = 16;
  localparam int unsigned c_bit_mi  = 15;
  localparam int unsigned c_bit_ri  = 14;
  localparam int unsigned c_bit_ro  = 13;
  localparam int unsigned c_bit_io  = 12;
  localparam int unsigned c_bit_ii  = 11;
  localparam int unsigned c_bit_ai  = 10;
  localparam int unsigned c_bit_ao  = 9;
  localparam int unsigned c_bit_bi  = 8;
  localparam int unsigned c_bit_bo  = 7;
  localparam int unsigned c_bit_eo  = 6;
  localparam int unsigned c_bit_su  = 5;
  localparam int unsigned c_bit_oi  = 4;
  localparam int unsigned c_bit_ce  = 3;
  localparam int unsigned c_bit_co  = 2;
  localparam int unsigned c_bit_j   = 1;
  localparam int unsigned c_bit_fi  = 0;

  // Indexed by opcode; entry 15 first. Length never depends on flags, so an
  // untaken conditional jump still burns its execute step.
  localparam logic [15:0][2:0] c_last_step_table = {
    3'd2,                               // 1111 HLT
    3'd2,                               // 1110 OUT
    3'd1, 3'd1, 3'd1, 3'd1, 3'd1,       // 1101..1001 undefined
    3'd2,                               // 1000 JZ
    3'd2,                               // 0111 JC
    3'd2,                               // 0110 JMP
    3'd2,                               // 0101 LDI
    3'd3,                               // 0100 STA
    3'd4,                               // 0011 SUB
    3'd4,                               // 0010 ADD
    3'd3,                               // 0001 LDA
    3'd1                                // 0000 NOP
  };

  function automatic logic [2:0] last_step(input logic [3:0] op);
    return c_last_step_table[op];
  endfunction

endpackage

`default_nettype wire

// File: rtl/control_rom.sv
// ============================================================================
// Module      : control_rom
// Description : Combinational microcode decode: opcode, step and flags to the
//               17-bit control word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_rom
  import control_sequencer_pkg::*;
#(
  parameter int STEP_BITS = 3
) (
  input  logic [3:0]              opcode,
  input  logic [STEP_BITS-1:0]    step,
  input  logic                    flag_c,
  input  logic                    flag_z,
  output logic [c_ctrl_width-1:0] ctrl
);

  localparam logic [STEP_BITS-1:0] c_s0 = STEP_BITS'(0);
  localparam logic [STEP_BITS-1:0] c_s1 = STEP_BITS'(1);
  localparam logic [STEP_BITS-1:0] c_s2 = STEP_BITS'(2);
  localparam logic [STEP_BITS-1:0] c_s3 = STEP_BITS'(3);
  localparam logic [STEP_BITS-1:0] c_s4 = STEP_BITS'(4);

  always_comb begin
    ctrl = '0;
    case (step)
      c_s0: begin
        ctrl[c_bit_co] = 1'b1;
        ctrl[c_bit_mi] = 1'b1;
      end
      c_s1: begin
        ctrl[c_bit_ro] = 1'b1;
        ctrl[c_bit_ii] = 1'b1;
        ctrl[c_bit_ce] = 1'b1;
      end
      c_s2: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            ctrl[c_bit_io] = 1'b1;
            ctrl[c_bit_mi] = 1'b1;
          end
          OP_LDI: begin
            ctrl[c_bit_io] = 1'b1;
            ctrl[c_bit_ai] = 1'b1;
          end
          OP_JMP: begin
            ctrl[c_bit_io] = 1'b1;
            ctrl[c_bit_j]  = 1'b1;
          end
          OP_JC: begin
            ctrl[c_bit_io] = flag_c;
            ctrl[c_bit_j]  = flag_c;
          end
          OP_JZ: begin
            ctrl[c_bit_io] = flag_z;
            ctrl[c_bit_j]  = flag_z;
          end
          OP_OUT: begin
            ctrl[c_bit_ao] = 1'b1;
            ctrl[c_bit_oi] = 1'b1;
          end
          OP_HLT: ctrl[c_bit_hlt] = 1'b1;
          default: ;
        endcase
      end
      c_s3: begin
        case (opcode)
          OP_LDA: begin
            ctrl[c_bit_ro] = 1'b1;
            ctrl[c_bit_ai] = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ctrl[c_bit_ro] = 1'b1;
            ctrl[c_bit_bi] = 1'b1;
          end
          OP_STA: begin
            ctrl[c_bit_ao] = 1'b1;
            ctrl[c_bit_ri] = 1'b1;
          end
          default: ;
        endcase
      end
      c_s4: begin
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          ctrl[c_bit_eo] = 1'b1;
          ctrl[c_bit_ai] = 1'b1;
          ctrl[c_bit_fi] = 1'b1;
          ctrl[c_bit_su] = (opcode == OP_SUB);
        end
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/control_sequencer.sv
// ============================================================================
// Module      : control_sequencer
// Description : Microstep counter and flags register driving the control ROM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int STEP_BITS = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           opcode,
  input  logic                 CY,
  input  logic                 Z,
  output logic                 HLT,
  output logic                 MI,
  output logic                 RI,
  output logic                 RO,
  output logic                 IO,
  output logic                 II,
  output logic                 AI,
  output logic                 AO,
  output logic                 BI,
  output logic                 BO,
  output logic                 EO,
  output logic                 SU,
  output logic                 OI,
  output logic                 CE,
  output logic                 CO,
  output logic                 J,
  output logic                 FI,
  output logic [STEP_BITS-1:0] step,
  output logic                 flag_c,
  output logic                 flag_z
);

  logic [STEP_BITS-1:0]    r_step;
  logic                    r_flag_c;
  logic                    r_flag_z;
  logic [c_ctrl_width-1:0] w_ctrl;
  logic [STEP_BITS-1:0]    w_last_step;

  control_rom #(
    .STEP_BITS (STEP_BITS)
  ) u_control_rom (
    .opcode (opcode),
    .step   (r_step),
    .flag_c (r_flag_c),
    .flag_z (r_flag_z),
    .ctrl   (w_ctrl)
  );

  assign w_last_step = STEP_BITS'(last_step(opcode));

  // HLT freezes the counter on its own step; only rst can move it again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_step   <= '0;
      r_flag_c <= 1'b0;
      r_flag_z <= 1'b0;
    end else begin
      if (!w_ctrl[c_bit_hlt]) begin
        if (r_step == w_last_step) r_step <= '0;
        else                       r_step <= r_step + STEP_BITS'(1);
      end
      if (w_ctrl[c_bit_fi]) begin
        r_flag_c <= CY;
        r_flag_z <= Z;
      end
    end
  end

  assign HLT    = w_ctrl[c_bit_hlt];
  assign MI     = w_ctrl[c_bit_mi];
  assign RI     = w_ctrl[c_bit_ri];
  assign RO     = w_ctrl[c_bit_ro];
  assign IO     = w_ctrl[c_bit_io];
  assign II     = w_ctrl[c_bit_ii];
  assign AI     = w_ctrl[c_bit_ai];
  assign AO     = w_ctrl[c_bit_ao];
  assign BI     = w_ctrl[c_bit_bi];
  assign BO     = w_ctrl[c_bit_bo];
  assign EO     = w_ctrl[c_bit_eo];
  assign SU     = w_ctrl[c_bit_su];
  assign OI     = w_ctrl[c_bit_oi];
  assign CE     = w_ctrl[c_bit_ce];
  assign CO     = w_ctrl[c_bit_co];
  assign J      = w_ctrl[c_bit_j];
  assign FI     = w_ctrl[c_bit_fi];
  assign step   = r_step;
  assign flag_c = r_flag_c;
  assign flag_z = r_flag_z;

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
// ============================================================================
// Module      : tb_control_sequencer
// Description : Directed vector bench for control_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_sequencer;
  import control_sequencer_pkg::*;

  // Bench-local control word order: HLT MI RI RO IO II AI AO BI BO EO SU OI CE CO J FI
  localparam logic [16:0] c_hlt = 17'h10000;
  localparam logic [16:0] c_mi  = 17'h08000;
  localparam logic [16:0] c_ri  = 17'h04000;
  localparam logic [16:0] c_ro  = 17'h02000;
  localparam logic [16:0] c_io  = 17'h01000;
  localparam logic [16:0] c_ii  = 17'h00800;
  localparam logic [16:0] c_ai  = 17'h00400;
  localparam logic [16:0] c_ao  = 17'h00200;
  localparam logic [16:0] c_bi  = 17'h00100;
  localparam logic [16:0] c_bo  = 17'h00080;
  localparam logic [16:0] c_eo  = 17'h00040;
  localparam logic [16:0] c_su  = 17'h00020;
  localparam logic [16:0] c_oi  = 17'h00010;
  localparam logic [16:0] c_ce  = 17'h00008;
  localparam logic [16:0] c_co  = 17'h00004;
  localparam logic [16:0] c_j   = 17'h00002;
  localparam logic [16:0] c_fi  = 17'h00001;
  localparam logic [16:0] c_f0  = c_co | c_mi;
  localparam logic [16:0] c_f1  = c_ro | c_ii | c_ce;
  localparam logic [16:0] c_drivers = c_ro | c_io | c_ao | c_bo | c_eo | c_co;
  localparam logic [16:0] c_loads   = c_mi | c_ri | c_ii | c_ai | c_bi | c_oi | c_j;

  typedef struct {
    logic [3:0]  op;
    logic        cy;
    logic        z;
    logic [2:0]  step;
    logic [16:0] ctrl;
    logic        fc;
    logic        fz;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic cy_in = 1'b0;
  logic z_in = 1'b0;
  logic w_hlt, w_mi, w_ri, w_ro, w_io, w_ii, w_ai, w_ao, w_bi, w_bo;
  logic w_eo, w_su, w_oi, w_ce, w_co, w_j, w_fi, w_flag_c, w_flag_z;
  logic [2:0] w_step;
  logic [16:0] w_obs;

  logic [3:0]              rom_op = 4'h0;
  logic [2:0]              rom_step = 3'd0;
  logic                    rom_fc = 1'b0;
  logic                    rom_fz = 1'b0;
  logic [c_ctrl_width-1:0] w_rom_ctrl;

  int n_tests = 0;
  int n_fail = 0;
  bit done = 1'b0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  control_sequencer #(.STEP_BITS(3)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .CY(cy_in), .Z(z_in),
    .HLT(w_hlt), .MI(w_mi), .RI(w_ri), .RO(w_ro), .IO(w_io), .II(w_ii),
    .AI(w_ai), .AO(w_ao), .BI(w_bi), .BO(w_bo), .EO(w_eo), .SU(w_su),
    .OI(w_oi), .CE(w_ce), .CO(w_co), .J(w_j), .FI(w_fi),
    .step(w_step), .flag_c(w_flag_c), .flag_z(w_flag_z)
  );

  control_rom #(.STEP_BITS(3)) u_rom (
    .opcode(rom_op), .step(rom_step), .flag_c(rom_fc), .flag_z(rom_fz),
    .ctrl(w_rom_ctrl)
  );

  assign w_obs = {w_hlt, w_mi, w_ri, w_ro, w_io, w_ii, w_ai, w_ao, w_bi,
                  w_bo, w_eo, w_su, w_oi, w_ce, w_co, w_j, w_fi};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] op, input logic cy, input logic z, input logic [2:0] st,
                     input logic [16:0] ctrl, input logic fc, input logic fz);
    vec_t v;
    v.op = op; v.cy = cy; v.z = z; v.step = st; v.ctrl = ctrl; v.fc = fc; v.fz = fz;
    vecs.push_back(v);
  endtask

  function automatic int popcount(input logic [16:0] w);
    int n = 0;
    for (int b = 0; b < 17; b++) n += int'(w[b]);
    return n;
  endfunction

  function automatic logic [16:0] remap(input logic [c_ctrl_width-1:0] c);
    return {c[c_bit_hlt], c[c_bit_mi], c[c_bit_ri], c[c_bit_ro], c[c_bit_io],
            c[c_bit_ii], c[c_bit_ai], c[c_bit_ao], c[c_bit_bi], c[c_bit_bo],
            c[c_bit_eo], c[c_bit_su], c[c_bit_oi], c[c_bit_ce], c[c_bit_co],
            c[c_bit_j], c[c_bit_fi]};
  endfunction

  initial begin
    #200000;
    if (!done) begin
      n_fail++;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  initial begin
    // Fetch is shared by every opcode; flags shown are the values before the edge.
    add(4'h1, 0, 0, 0, c_f0, 0, 0); add(4'h1, 0, 0, 1, c_f1, 0, 0);
    add(4'h1, 0, 0, 2, c_io | c_mi, 0, 0); add(4'h1, 0, 0, 3, c_ro | c_ai, 0, 0);
    add(4'h2, 1, 0, 0, c_f0, 0, 0); add(4'h2, 1, 0, 1, c_f1, 0, 0);
    add(4'h2, 1, 0, 2, c_io | c_mi, 0, 0); add(4'h2, 1, 0, 3, c_ro | c_bi, 0, 0);
    add(4'h2, 1, 0, 4, c_eo | c_ai | c_fi, 0, 0);
    add(4'h3, 0, 1, 0, c_f0, 1, 0); add(4'h3, 0, 1, 1, c_f1, 1, 0);
    add(4'h3, 0, 1, 2, c_io | c_mi, 1, 0); add(4'h3, 0, 1, 3, c_ro | c_bi, 1, 0);
    add(4'h3, 0, 1, 4, c_eo | c_ai | c_fi | c_su, 1, 0);
    add(4'h7, 1, 0, 0, c_f0, 0, 1); add(4'h7, 1, 0, 1, c_f1, 0, 1);
    add(4'h7, 1, 0, 2, 17'h0, 0, 1);
    add(4'h8, 1, 0, 0, c_f0, 0, 1); add(4'h8, 1, 0, 1, c_f1, 0, 1);
    add(4'h8, 1, 0, 2, c_io | c_j, 0, 1);
    add(4'hA, 1, 1, 0, c_f0, 0, 1); add(4'hA, 1, 1, 1, c_f1, 0, 1);
    add(4'h5, 1, 1, 0, c_f0, 0, 1); add(4'h5, 1, 1, 1, c_f1, 0, 1);
    add(4'h5, 1, 1, 2, c_io | c_ai, 0, 1);
    add(4'hE, 1, 1, 0, c_f0, 0, 1); add(4'hE, 1, 1, 1, c_f1, 0, 1);
    add(4'hE, 1, 1, 2, c_ao | c_oi, 0, 1);
    add(4'h6, 1, 1, 0, c_f0, 0, 1); add(4'h6, 1, 1, 1, c_f1, 0, 1);
    add(4'h6, 1, 1, 2, c_io | c_j, 0, 1);
    add(4'h0, 1, 1, 0, c_f0, 0, 1); add(4'h0, 1, 1, 1, c_f1, 0, 1);
    add(4'hD, 1, 1, 0, c_f0, 0, 1); add(4'hD, 1, 1, 1, c_f1, 0, 1);
    add(4'h9, 1, 1, 0, c_f0, 0, 1); add(4'h9, 1, 1, 1, c_f1, 0, 1);
    add(4'h2, 1, 0, 0, c_f0, 0, 1); add(4'h2, 1, 0, 1, c_f1, 0, 1);
    add(4'h2, 1, 0, 2, c_io | c_mi, 0, 1); add(4'h2, 1, 0, 3, c_ro | c_bi, 0, 1);
    add(4'h2, 1, 0, 4, c_eo | c_ai | c_fi, 0, 1);
    add(4'h7, 0, 1, 0, c_f0, 1, 0); add(4'h7, 0, 1, 1, c_f1, 1, 0);
    add(4'h7, 0, 1, 2, c_io | c_j, 1, 0);
    add(4'h8, 0, 1, 0, c_f0, 1, 0); add(4'h8, 0, 1, 1, c_f1, 1, 0);
    add(4'h8, 0, 1, 2, 17'h0, 1, 0);
    add(4'h4, 0, 1, 0, c_f0, 1, 0); add(4'h4, 0, 1, 1, c_f1, 1, 0);
    add(4'h4, 0, 1, 2, c_io | c_mi, 1, 0); add(4'h4, 0, 1, 3, c_ao | c_ri, 1, 0);
    add(4'h0, 0, 0, 0, c_f0, 1, 0); add(4'h0, 0, 0, 1, c_f1, 1, 0);

    // Asynchronous reset well before the first rising edge.
    #1 rst = 1'b1;
    #1 check("reset_async", {12'h0, w_step, w_obs}, {12'h0, 3'd0, c_f0});
    check("reset_flags", {30'h0, w_flag_c, w_flag_z}, 32'h0);
    opcode = 4'h1;
    repeat (2) @(negedge clk);
    check("reset_held", {10'h0, w_step, w_obs, w_flag_c, w_flag_z}, {10'h0, 3'd0, c_f0, 2'b00});
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      opcode = vecs[i].op;
      cy_in  = vecs[i].cy;
      z_in   = vecs[i].z;
      #1;
      check($sformatf("vec%0d_op%h_s%0d", i, vecs[i].op, vecs[i].step),
            {10'h0, w_step, w_obs, w_flag_c, w_flag_z},
            {10'h0, vecs[i].step, vecs[i].ctrl, vecs[i].fc, vecs[i].fz});
      @(negedge clk);
    end

    // Reset in the middle of STA with flag_c set, no clock edge involved.
    opcode = 4'h4; cy_in = 1'b1; z_in = 1'b1;
    repeat (3) @(negedge clk);
    #1 check("sta_step3", {15'h0, w_step, w_obs}, {15'h0, 3'd3, c_ao | c_ri});
    #1 rst = 1'b1;
    #1 check("sta_rst_async", {10'h0, w_step, w_obs, w_flag_c, w_flag_z}, {10'h0, 3'd0, c_f0, 2'b00});
    #1 rst = 1'b0;
    @(negedge clk);
    check("sta_rst_resume", {15'h0, w_step, w_obs}, {15'h0, 3'd1, c_f1});

    // HLT holds step 2 until reset.
    opcode = 4'hF;
    @(negedge clk);
    check("hlt_step2", {15'h0, w_step, w_obs}, {15'h0, 3'd2, c_hlt});
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("hlt_hold%0d", k), {29'h0, w_step}, {29'h0, 3'd2});
    end
    #2 rst = 1'b1;
    #1 check("hlt_rst_async", {15'h0, w_step, w_obs}, {15'h0, 3'd0, c_f0});
    @(negedge clk);
    check("hlt_rst_held", {15'h0, w_step, w_obs}, {15'h0, 3'd0, c_f0});
    rst = 1'b0;
    opcode = 4'h0;
    @(negedge clk);
    check("hlt_resume", {15'h0, w_step, w_obs}, {15'h0, 3'd1, c_f1});

    // Bus-driver and load exclusivity over every opcode, step and flag pair.
    for (int op = 0; op < 16; op++) begin
      for (int st = 0; st < 5; st++) begin
        for (int fl = 0; fl < 4; fl++) begin
          rom_op   = 4'(op);
          rom_step = 3'(st);
          rom_fc   = fl[1];
          rom_fz   = fl[0];
          #1;
          check($sformatf("excl_op%h_s%0d_f%0d", op, st, fl),
                {30'h0, popcount(remap(w_rom_ctrl) & c_drivers) <= 1,
                        popcount(remap(w_rom_ctrl) & c_loads) <= 1},
                32'h3);
        end
      end
    end

    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
